// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : calc_pkg
// Brief   : Shared constants and state encoding for the FSM calculator.
// Revision: 1.0 - initial release
// ============================================================================
package calc_pkg;

  localparam int c_calc_w       = 8;
  localparam int c_calc_timeout = 255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GET_B = 2'd1,
    EXEC  = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/calc_sub_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : calc_sub_sequencer
// Brief   : Collects A/B operand bytes, issues one subtractor_8bit cycle and
//           holds the captured Diff/borrow until acknowledged.
// Revision: 1.0 - initial release
// ============================================================================
module calc_sub_sequencer
  import calc_pkg::*;
#(
  parameter int W       = c_calc_w,
  parameter int TIMEOUT = c_calc_timeout
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  output logic         din_ready,
  input  logic         chain,
  output logic [W-1:0] sub_a,
  output logic [W-1:0] sub_b,
  output logic         sub_bin,
  input  logic [W-1:0] sub_diff,
  input  logic         sub_err,
  output logic [W-1:0] res,
  output logic         res_err,
  output logic         res_valid,
  input  logic         res_ack,
  output logic         timeout_err
);

  localparam int                 c_cnt_w    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t             r_state;
  logic [W-1:0]       r_a;
  logic [W-1:0]       r_b;
  logic               r_bin;
  logic               r_chain;
  logic               r_borrow;
  logic [W-1:0]       r_res;
  logic               r_res_err;
  logic               r_res_valid;
  logic               r_timeout;
  logic [c_cnt_w-1:0] r_idle_cnt;
  logic               w_xfer;

  assign din_ready   = (r_state == IDLE) || (r_state == GET_B);
  assign w_xfer      = din_valid & din_ready;
  assign sub_a       = r_a;
  assign sub_b       = r_b;
  assign sub_bin     = r_bin;
  assign res         = r_res;
  assign res_err     = r_res_err;
  assign res_valid   = r_res_valid;
  assign timeout_err = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_a         <= '0;
      r_b         <= '0;
      r_bin       <= 1'b0;
      r_chain     <= 1'b0;
      r_borrow    <= 1'b0;
      r_res       <= '0;
      r_res_err   <= 1'b0;
      r_res_valid <= 1'b0;
      r_timeout   <= 1'b0;
      r_idle_cnt  <= '0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_a        <= din;
            r_chain    <= chain;
            r_idle_cnt <= '0;
            r_state    <= GET_B;
          end
        end
        GET_B: begin
          if (w_xfer) begin
            r_b     <= din;
            // BorrowIn is settled before EXEC so the subtractor sees stable inputs
            r_bin   <= r_chain & r_borrow;
            r_state <= EXEC;
          end else if ((TIMEOUT != 0) && (r_idle_cnt == c_cnt_last)) begin
            r_timeout <= 1'b1;
            r_a       <= '0;
            r_state   <= IDLE;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        EXEC: begin
          r_res       <= sub_diff;
          r_res_err   <= sub_err;
          r_borrow    <= sub_err;
          r_res_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (res_ack) begin
            r_res_valid <= 1'b0;
            r_bin       <= 1'b0;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
